// File: rtl/load_sequencer_if.sv
// Push-side handshake bundle for load_sequencer.
//   in_valid : producer offers in_data this cycle
//   in_data  : 8-bit preset value to queue
//   in_ready : sequencer can accept a value this cycle
interface load_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/load_sequencer.sv
// Queues preset values and feeds them to a downstream 8-bit counter, issuing a
// load strobe on priming and whenever the counter reaches terminal count.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   push        : in_valid/in_data/in_ready handshake (slave side)
//   enable      : sequencing permitted
//   cnt         : current counter value
//   load, data  : counter load strobe and load value (combinational)
//   fifo_count  : queued entries, 0..4
//   underrun    : sticky, terminal count reached with an empty queue
module load_sequencer (
  input  logic                   clk,
  input  logic                   rst,
  load_sequencer_if.slave        push,
  input  logic                   enable,
  input  logic [7:0]             cnt,
  output logic                   load,
  output logic [7:0]             data,
  output logic [2:0]             fifo_count,
  output logic                   underrun
);

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            r_underrun;

  logic            w_empty;
  logic            w_full;
  logic            w_tc;
  logic            w_load;
  logic            w_push;
  logic            w_pop;

  assign w_empty = (r_count == CW'(0));
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_tc    = (r_state == RUN) && enable && (cnt == 8'hFF);

  // Load on the priming cycle, or at terminal count when a value is queued.
  assign w_load  = !w_empty && ((r_state == PRIME) || w_tc);

  // Full blocks pushes even when a pop happens the same cycle.
  assign w_push  = push.in_valid && !w_full;
  assign w_pop   = w_load;

  // Outputs forced to their reset values while rst is held.
  assign load          = w_load && !rst;
  assign data          = (rst || w_empty) ? DW'(0) : r_mem[r_rd_ptr];
  assign push.in_ready = rst || !w_full;
  assign fifo_count    = r_count;
  assign underrun      = r_underrun;

  // Queue storage; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= push.in_data;
    end
  end

  // Sequencer state, queue pointers/occupancy and sticky underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd_ptr   <= PW'(0);
      r_wr_ptr   <= PW'(0);
      r_count    <= CW'(0);
      r_underrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_tc && w_empty) r_underrun <= 1'b1;

      unique case (r_state)
        IDLE:    if (enable && !w_empty) r_state <= PRIME;
        PRIME:   r_state <= RUN;
        RUN:     if (!enable) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
module tb_load_sequencer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] cnt;
  logic       load;
  logic [7:0] data;
  logic [2:0] fifo_count;
  logic       underrun;

  load_sequencer_if intf ();

  load_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .push       (intf),
    .enable     (enable),
    .cnt        (cnt),
    .load       (load),
    .data       (data),
    .fifo_count (fifo_count),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       en;
    logic [7:0] cnt;
    logic       e_load;
    logic [7:0] e_data;
    logic       e_ready;
    logic [2:0] e_count;
    logic       e_ur;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic en, logic [7:0] c,
                              logic el, logic [7:0] ed, logic er, logic [2:0] ec, logic eu);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.en = en; t.cnt = c;
    t.e_load = el; t.e_data = ed; t.e_ready = er; t.e_count = ec; t.e_ur = eu;
    return t;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [7:0] d,
                       input logic en, input logic [7:0] c);
    rst = r; intf.in_valid = v; intf.in_data = d; enable = en; cnt = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: queue of bytes plus the three-phase sequencer.
  typedef enum {M_IDLE, M_PRIME, M_RUN} mphase_t;
  logic [7:0] mq[$];
  mphase_t    mph;
  logic       mur;

  task automatic model_step(input logic r, input logic v, input logic [7:0] d,
                            input logic en, input logic [7:0] c,
                            output logic el, output logic [7:0] ed, output logic er);
    int sz;
    logic ld;
    sz = mq.size();
    ld = (sz > 0) && ((mph == M_PRIME) || (mph == M_RUN && en && c == 8'hFF));
    el = r ? 1'b0 : ld;
    ed = (r || sz == 0) ? 8'h00 : mq[0];
    er = r ? 1'b1 : (sz != 4);
    if (r) begin
      mq.delete();
      mph = M_IDLE;
      mur = 1'b0;
    end else begin
      if (mph == M_RUN && en && c == 8'hFF && sz == 0) mur = 1'b1;
      if (ld) void'(mq.pop_front());
      if (v && sz != 4) mq.push_back(d);
      case (mph)
        M_IDLE:  if (en && sz != 0) mph = M_PRIME;
        M_PRIME: mph = M_RUN;
        default: if (!en) mph = M_IDLE;
      endcase
    end
  endtask

  initial begin
    logic el, er;
    logic [7:0] ed;

    // Reset state
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    tick(); tick();
    chk("rst_load",  int'(load), 0);
    chk("rst_data",  int'(data), 0);
    chk("rst_ready", int'(intf.in_ready), 1);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ur",    int'(underrun), 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // rst v d en cnt | load data ready (pre-edge) | count ur (post-edge)
    vecs.push_back(mk(0,1,8'h10,0,8'h00, 0,8'h00,1, 1,0)); // fill
    vecs.push_back(mk(0,1,8'h20,0,8'h00, 0,8'h10,1, 2,0));
    vecs.push_back(mk(0,1,8'h30,0,8'h00, 0,8'h10,1, 3,0));
    vecs.push_back(mk(0,1,8'h40,0,8'h00, 0,8'h10,1, 4,0));
    vecs.push_back(mk(0,1,8'h50,0,8'h00, 0,8'h10,0, 4,0)); // full, rejected
    vecs.push_back(mk(0,1,8'h60,0,8'h00, 0,8'h10,0, 4,0));
    vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,8'h00,1, 0,0)); // reset
    vecs.push_back(mk(0,1,8'h10,0,8'h00, 0,8'h00,1, 1,0)); // prime setup
    vecs.push_back(mk(0,1,8'h20,0,8'h00, 0,8'h10,1, 2,0));
    vecs.push_back(mk(0,0,8'h00,1,8'h00, 0,8'h10,1, 2,0)); // IDLE->PRIME
    vecs.push_back(mk(0,0,8'h00,1,8'h00, 1,8'h10,1, 1,0)); // PRIME load
    vecs.push_back(mk(0,0,8'h00,1,8'hFE, 0,8'h20,1, 1,0)); // terminal count
    vecs.push_back(mk(0,0,8'h00,1,8'hFF, 1,8'h20,1, 0,0));
    vecs.push_back(mk(0,0,8'h00,1,8'hFF, 0,8'h00,1, 0,1)); // underrun
    vecs.push_back(mk(0,0,8'h00,1,8'h00, 0,8'h00,1, 0,1)); // sticky
    vecs.push_back(mk(0,1,8'hAA,1,8'h10, 0,8'h00,1, 1,1));
    vecs.push_back(mk(0,1,8'hBB,1,8'h10, 0,8'hAA,1, 2,1));
    vecs.push_back(mk(0,1,8'h55,1,8'hFF, 1,8'hAA,1, 2,1)); // push+pop
    vecs.push_back(mk(0,0,8'h00,1,8'hFF, 1,8'hBB,1, 1,1)); // back-to-back
    vecs.push_back(mk(0,0,8'h00,1,8'h10, 0,8'h55,1, 1,1)); // 55 last
    vecs.push_back(mk(0,0,8'h00,0,8'hFF, 0,8'h55,1, 1,1)); // disable at tc
    vecs.push_back(mk(0,0,8'h00,0,8'hFF, 0,8'h55,1, 1,1));
    vecs.push_back(mk(0,0,8'h00,1,8'h00, 0,8'h55,1, 1,1)); // IDLE->PRIME
    vecs.push_back(mk(0,0,8'h00,1,8'h00, 1,8'h55,1, 0,1));
    vecs.push_back(mk(0,1,8'h01,1,8'h00, 0,8'h00,1, 1,1));
    vecs.push_back(mk(0,1,8'h02,1,8'h00, 0,8'h01,1, 2,1));
    vecs.push_back(mk(0,1,8'h03,1,8'h00, 0,8'h01,1, 3,1));
    vecs.push_back(mk(1,0,8'h00,1,8'h00, 0,8'h00,1, 0,0)); // reset in RUN
    vecs.push_back(mk(0,0,8'h00,1,8'hFF, 0,8'h00,1, 0,0));
    vecs.push_back(mk(0,0,8'h00,1,8'hFF, 0,8'h00,1, 0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].en, vecs[i].cnt);
      #1;
      chk($sformatf("v%0d_load",  i), int'(load),          int'(vecs[i].e_load));
      chk($sformatf("v%0d_data",  i), int'(data),          int'(vecs[i].e_data));
      chk($sformatf("v%0d_ready", i), int'(intf.in_ready), int'(vecs[i].e_ready));
      tick();
      chk($sformatf("v%0d_count", i), int'(fifo_count),    int'(vecs[i].e_count));
      chk($sformatf("v%0d_ur",    i), int'(underrun),      int'(vecs[i].e_ur));
    end

    // Reset asserted during the priming cycle
    drive(0, 1, 8'h77, 0, 8'h00); tick();
    chk("pr_count0", int'(fifo_count), 1);
    drive(0, 0, 8'h00, 1, 8'h00); tick();
    drive(1, 0, 8'h00, 1, 8'h00); #1;
    chk("pr_load_in_rst", int'(load), 0);
    chk("pr_data_in_rst", int'(data), 0);
    tick();
    chk("pr_count_after", int'(fifo_count), 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 8'h00, 1, 8'hFF); #1;
      chk($sformatf("pr_noload%0d", k), int'(load), 0);
      tick();
    end
    chk("pr_ur", int'(underrun), 0);

    // Randomized run against the reference model
    drive(1, 0, 8'h00, 0, 8'h00);
    tick();
    mq.delete(); mph = M_IDLE; mur = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r, v, en;
      logic [7:0] d, c;
      r  = ($urandom_range(0, 63) == 0);
      v  = ($urandom_range(0, 1) == 1);
      d  = 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      drive(r, v, d, en, c);
      model_step(r, v, d, en, c, el, ed, er);
      #1;
      chk($sformatf("r%0d_load",  i), int'(load),          int'(el));
      chk($sformatf("r%0d_data",  i), int'(data),          int'(ed));
      chk($sformatf("r%0d_ready", i), int'(intf.in_ready), int'(er));
      tick();
      chk($sformatf("r%0d_count", i), int'(fifo_count),    mq.size());
      chk($sformatf("r%0d_ur",    i), int'(underrun),      int'(mur));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  in  1  preset value offered on in_data.
REQ-005 in_data  in  8  preset value to be queued.
REQ-006 in_ready  out  1  queue can accept a value this cycle.
REQ-007 enable  in  1  sequencing permitted.
REQ-008 cnt  in  8  current value of the downstream 8-bit counter output.
REQ-009 load  out  1  load strobe, wired to the counter's load input.
REQ-010 data  out  8  load value, wired to the counter's data input.
REQ-011 fifo_count  out  3  number of queued entries, 0..4.
REQ-012 underrun  out  1  sticky flag: terminal count was reached with the queue empty.

Function
REQ-013 The block SHALL hold a 4-entry first-in, first-out queue of 8-bit values.
REQ-014 in_ready SHALL equal (fifo_count != 4).
REQ-015 A push SHALL occur on any edge where in_valid && in_ready.
- When the queue is full, in_ready is 0 even if a pop happens in the same cycle.
REQ-016 data SHALL always present the queue head, combinationally.
- When the queue is empty, data SHALL be 8'h00.
REQ-017 A pop SHALL occur exactly on every edge where load is 1.
REQ-018 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-019 The state machine SHALL have three states: IDLE, PRIME and RUN.
REQ-020 IDLE SHALL go to PRIME when enable && fifo_count != 0; otherwise it stays in IDLE.
REQ-021 PRIME SHALL last exactly one cycle with load = 1, then go to RUN.
REQ-022 RUN SHALL go to IDLE on any edge where enable == 0.
- No load is issued in that cycle.
REQ-023 In RUN with enable = 1 and cnt == 8'hFF, load SHALL be 1 if the queue is non-empty.
- The counter therefore loads the head value instead of wrapping to 8'h00.
REQ-024 In RUN with enable = 1, cnt == 8'hFF and an empty queue:
- load SHALL stay 0 (the counter wraps);
- underrun SHALL be set on that edge.
REQ-025 load SHALL be combinational from state, enable, cnt and queue-empty.
- load has zero-cycle latency to the counter's next edge.
REQ-026 load SHALL be 0 in all cases other than those in REQ-021 and REQ-023.
REQ-027 A value of 8'hFF loaded by the block SHALL cause a further load on the next cycle if the queue is non-empty.
- This is legal back-to-back loading.
REQ-028 underrun SHALL be cleared only by rst.
REQ-029 fifo_count SHALL never exceed 4 or wrap below 0.
- A pop SHALL never be issued on an empty queue.

Reset
REQ-030 While rst = 1 at an edge, the block SHALL apply the following:
- state <= IDLE;
- queue emptied (contents discarded);
- fifo_count <= 0;
- underrun <= 0.
REQ-031 During and after reset, the outputs SHALL read: load = 0, data = 8'h00, in_ready = 1.
REQ-032 rst SHALL take priority over push, pop and all state transitions, including a reset asserted mid-operation in PRIME or RUN.

Verification
REQ-033 Fill: push 8'h10, 8'h20, 8'h30, 8'h40 with enable = 0, then hold in_valid = 1.
- Required: fifo_count = 4, in_ready = 0, the fifth value is not accepted, load stays 0.
REQ-034 Prime: with queue {8'h10, 8'h20}, raise enable.
- Required: one cycle later load = 1, data = 8'h10; next edge fifo_count = 1, state RUN.
REQ-035 Terminal count: in RUN with queue {8'h20}, drive cnt = 8'hFE then 8'hFF.
- Required: load = 1 with data = 8'h20 only in the 8'hFF cycle; fifo_count then 0.
REQ-036 Underrun: in RUN with an empty queue, drive cnt = 8'hFF.
- Required: load = 0; underrun = 1 after the edge and stays 1 until rst.
REQ-037 Simultaneous events:
- with fifo_count = 2, push 8'h55 in the same cycle as a terminal-count pop -> fifo_count stays 2 and 8'h55 is last in order;
- in RUN, enable = 0 in the same cycle as cnt = 8'hFF -> load = 0 and the next state is IDLE.
REQ-038 Reset mid-operation: assert rst for 1 cycle in RUN with fifo_count = 3.
- Required: fifo_count = 0, underrun = 0, state IDLE, in_ready = 1.
- With enable held at 1 and no pushes, no load is issued.
